// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for a 256x8 level-sensitive
// single-port memory. Each command runs SETUP -> ACCESS -> RESP with registered pins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,

  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,

  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read_write,
  output logic              mem_chip_en,
  input  logic [DATA_W-1:0] mem_data_out,

  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  state_e              state_q;
  logic                owner_q;
  logic                last_owner_q;
  logic [1:0]          gnt_q;
  logic [1:0]          done_q;
  logic                ce_q;
  logic                rw_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;

  logic                any_req;
  logic                win_sel;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  // On a tie the requester that did not own the previous transaction wins.
  always_comb begin
    any_req = r0_req | r1_req;
    win_sel = r1_req;
    if (r0_req && r1_req) begin
      win_sel = ~last_owner_q;
    end
    win_we    = win_sel ? r1_we    : r0_we;
    win_addr  = win_sel ? r1_addr  : r0_addr;
    win_wdata = win_sel ? r1_wdata : r0_wdata;
  end

  // The latched command lives directly in the pin registers, so address, data and
  // read_write are stable from SETUP through RESP around the single chip_en cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      ce_q         <= 1'b0;
      rw_q         <= 1'b0;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q      <= StSetup;
            owner_q      <= win_sel;
            last_owner_q <= win_sel;
            addr_q       <= win_addr;
            wdata_q      <= win_wdata;
            rw_q         <= win_we;
            gnt_q        <= win_sel ? 2'b10 : 2'b01;
            busy_q       <= 1'b1;
          end
        end
        StSetup: begin
          gnt_q   <= 2'b00;
          ce_q    <= 1'b1;
          state_q <= StAccess;
        end
        StAccess: begin
          ce_q <= 1'b0;
          if (!rw_q) begin
            if (owner_q) begin
              rdata1_q <= mem_data_out;
            end else begin
              rdata0_q <= mem_data_out;
            end
          end
          done_q  <= owner_q ? 2'b10 : 2'b01;
          state_q <= StResp;
        end
        StResp: begin
          done_q  <= 2'b00;
          rw_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign r0_gnt         = gnt_q[0];
  assign r1_gnt         = gnt_q[1];
  assign r0_done        = done_q[0];
  assign r1_done        = done_q[1];
  assign r0_rdata       = rdata0_q;
  assign r1_rdata       = rdata1_q;
  assign mem_address    = addr_q;
  assign mem_data_in    = wdata_q;
  assign mem_read_write = rw_q;
  assign mem_chip_en    = ce_q;
  assign busy           = busy_q;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) !(r0_gnt && r1_gnt));
  a_done_onehot : assert property (@(posedge clk) disable iff (rst) !(r0_done && r1_done));
  a_ce_busy : assert property (@(posedge clk) disable iff (rst) mem_chip_en |-> busy);
  a_pins_stable : assert property (@(posedge clk) disable iff (rst)
      mem_chip_en |-> ($stable(mem_address) && $stable(mem_read_write)
                       && $stable(mem_data_in)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline reference model compared every cycle,
// directed scenarios with literal expectations, then randomized two-master traffic.
module tb_mem_port_arbiter;

  localparam int NCMD = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rq   [2];
  logic       we_v [2];
  logic [7:0] ad_v [2];
  logic [7:0] wd_v [2];

  logic       r0_gnt, r0_done, r1_gnt, r1_done;
  logic [7:0] r0_rdata, r1_rdata;
  logic [7:0] mem_address, mem_data_in, mem_data_out;
  logic       mem_read_write, mem_chip_en, busy;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .r0_req         (rq[0]),
    .r0_we          (we_v[0]),
    .r0_addr        (ad_v[0]),
    .r0_wdata       (wd_v[0]),
    .r0_gnt         (r0_gnt),
    .r0_done        (r0_done),
    .r0_rdata       (r0_rdata),
    .r1_req         (rq[1]),
    .r1_we          (we_v[1]),
    .r1_addr        (ad_v[1]),
    .r1_wdata       (wd_v[1]),
    .r1_gnt         (r1_gnt),
    .r1_done        (r1_done),
    .r1_rdata       (r1_rdata),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_read_write (mem_read_write),
    .mem_chip_en    (mem_chip_en),
    .mem_data_out   (mem_data_out),
    .busy           (busy)
  );

  // Memory the DUT talks to.
  logic [7:0] mem [256] = '{default: 8'h00};
  assign mem_data_out = (mem_chip_en && !mem_read_write) ? mem[mem_address] : 8'h00;
  always @(posedge clk) begin
    if (mem_chip_en && mem_read_write) mem[mem_address] <= mem_data_in;
  end

  // Reference model: a transaction granted at cycle tg has chip_en at tg+1, done at tg+2,
  // and the arbiter is free to sample again at tg+3.
  int         cyc = 0;
  int         m_tg = -100;
  int         m_idle = 0;
  logic       m_own = 1'b0;
  logic       m_last = 1'b1;
  logic       m_we = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_wd = 8'h00;
  logic [7:0] m_rd0 = 8'h00;
  logic [7:0] m_rd1 = 8'h00;
  logic [7:0] mem_ref [256] = '{default: 8'h00};
  logic       m_win;

  assign m_win = (rq[0] && rq[1]) ? !m_last : rq[1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tg <= -100;
      m_idle <= 0;
      m_last <= 1'b1;
      m_own <= 1'b0;
      m_we <= 1'b0;
      m_addr <= 8'h00;
      m_wd <= 8'h00;
      m_rd0 <= 8'h00;
      m_rd1 <= 8'h00;
    end else begin
      if (cyc == m_tg + 1) begin
        if (m_we) mem_ref[m_addr] <= m_wd;
        else if (m_own) m_rd1 <= mem_ref[m_addr];
        else m_rd0 <= mem_ref[m_addr];
      end
      if (cyc >= m_idle && (rq[0] || rq[1])) begin
        m_own  <= m_win;
        m_last <= m_win;
        m_tg   <= cyc + 1;
        m_idle <= cyc + 4;
        m_we   <= m_win ? we_v[1] : we_v[0];
        m_addr <= m_win ? ad_v[1] : ad_v[0];
        m_wd   <= m_win ? wd_v[1] : wd_v[0];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_compare();
    int   t;
    logic win;
    t   = cyc - m_tg;
    win = (t >= 0 && t <= 2);
    check("gnt0", 32'(r0_gnt), 32'(t == 0 && !m_own));
    check("gnt1", 32'(r1_gnt), 32'(t == 0 && m_own));
    check("chip_en", 32'(mem_chip_en), 32'(t == 1));
    check("done0", 32'(r0_done), 32'(t == 2 && !m_own));
    check("done1", 32'(r1_done), 32'(t == 2 && m_own));
    check("busy", 32'(busy), 32'(win));
    check("read_write", 32'(mem_read_write), 32'(win ? m_we : 1'b0));
    check("address", 32'(mem_address), 32'(m_addr));
    check("data_in", 32'(mem_data_in), 32'(m_wd));
    check("rdata0", 32'(r0_rdata), 32'(m_rd0));
    check("rdata1", 32'(r1_rdata), 32'(m_rd1));
  endtask

  task automatic tick();
    @(negedge clk);
    model_compare();
  endtask

  task automatic txn(input int n, input logic we, input logic [7:0] a, input logic [7:0] d,
                     output int gc, output int dc);
    tick();
    we_v[n] = we;
    ad_v[n] = a;
    wd_v[n] = d;
    rq[n]   = 1'b1;
    gc = -1;
    dc = -1;
    for (int c = 1; c <= 12 && dc < 0; c++) begin
      tick();
      if ((n == 1 ? r1_gnt : r0_gnt) && gc < 0) begin
        gc = c;
        rq[n] = 1'b0;
        ad_v[n] = 8'($urandom);
        wd_v[n] = 8'($urandom);
      end
      if (n == 1 ? r1_done : r0_done) dc = c;
    end
  endtask

  logic       cmd_we [2][NCMD];
  logic [7:0] cmd_ad [2][NCMD];
  logic [7:0] cmd_wd [2][NCMD];
  int         cmd_gap[2][NCMD];
  int         head [2];
  int         gapc [2];
  int         gcy [4];
  logic       gown [4];
  logic [7:0] solo_ad [3] = '{8'h10, 8'hFF, 8'h10};
  logic [7:0] solo_ex [3] = '{8'hA5, 8'h3C, 8'hA5};

  task automatic present(input int n);
    we_v[n] = cmd_we[n][head[n]];
    ad_v[n] = cmd_ad[n][head[n]];
    wd_v[n] = cmd_wd[n][head[n]];
    rq[n]   = 1'b1;
  endtask

  task automatic drive_step();
    logic g;
    for (int n = 0; n < 2; n++) begin
      g = (n == 1) ? r1_gnt : r0_gnt;
      if (rq[n] && g) begin
        head[n]++;
        if (head[n] < NCMD && cmd_gap[n][head[n]] == 0) begin
          present(n);
        end else begin
          rq[n] = 1'b0;
          gapc[n] = (head[n] < NCMD) ? cmd_gap[n][head[n]] : 0;
          we_v[n] = 1'($urandom);
          ad_v[n] = 8'($urandom);
          wd_v[n] = 8'($urandom);
        end
      end else if (!rq[n] && head[n] < NCMD) begin
        if (gapc[n] > 0) gapc[n]--;
        else present(n);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, g1, gc, dc, k, kd, ng, both, r0g, ngr, cy;

    // Reset with both requesters active: r0 writes 0x10<=0xA5, r1 writes 0xFF<=0x3C.
    rq[0] = 1'b1; we_v[0] = 1'b1; ad_v[0] = 8'h10; wd_v[0] = 8'hA5;
    rq[1] = 1'b1; we_v[1] = 1'b1; ad_v[1] = 8'hFF; wd_v[1] = 8'h3C;
    tick(); tick(); tick();
    check("rst_gnt0", 32'(r0_gnt), 32'd0);
    check("rst_gnt1", 32'(r1_gnt), 32'd0);
    check("rst_chip_en", 32'(mem_chip_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done0", 32'(r0_done), 32'd0);
    check("rst_address", 32'(mem_address), 32'd0);
    rst = 1'b0;
    g0 = -1; g1 = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (r0_gnt && g0 < 0) begin g0 = c; rq[0] = 1'b0; end
      if (r1_gnt && g1 < 0) begin g1 = c; rq[1] = 1'b0; end
      if (c == 2) begin
        check("wr_chip_en", 32'(mem_chip_en), 32'd1);
        check("wr_read_write", 32'(mem_read_write), 32'd1);
        check("wr_address", 32'(mem_address), 32'h10);
        check("wr_data_in", 32'(mem_data_in), 32'hA5);
      end
      if (c == 3) check("wr_done0", 32'(r0_done), 32'd1);
    end
    check("first_tie_gnt0_cycle", 32'(g0), 32'd1);
    check("first_tie_gnt1_cycle", 32'(g1), 32'd5);

    // r0 reads back its write, then reads r1's write.
    txn(0, 1'b0, 8'h10, 8'h00, gc, dc);
    check("rd_gnt_cycle", 32'(gc), 32'd1);
    check("rd_done_cycle", 32'(dc), 32'd3);
    check("rd_rdata0", 32'(r0_rdata), 32'hA5);
    txn(0, 1'b0, 8'hFF, 8'h00, gc, dc);
    check("cross_rdata0", 32'(r0_rdata), 32'h3C);
    check("cross_rdata1", 32'(r1_rdata), 32'h00);

    // Solo r1: three back-to-back reads.
    tick();
    we_v[1] = 1'b0; ad_v[1] = solo_ad[0]; rq[1] = 1'b1;
    k = 0; kd = 0; r0g = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (r0_gnt) r0g++;
      if (r1_gnt && k < 3) begin
        gcy[k] = c;
        k++;
        if (k < 3) ad_v[1] = solo_ad[k];
        else rq[1] = 1'b0;
      end
      if (r1_done && kd < 3) begin
        check("solo_rdata1", 32'(r1_rdata), 32'(solo_ex[kd]));
        kd++;
      end
    end
    check("solo_grants", 32'(k), 32'd3);
    check("solo_dones", 32'(kd), 32'd3);
    check("solo_r0_gnts", 32'(r0g), 32'd0);
    for (int i = 0; i < 3; i++) check("solo_gnt_cycle", 32'(gcy[i]), 32'(1 + 4 * i));

    // Contention: both hold req continuously.
    tick();
    we_v[0] = 1'b0; ad_v[0] = 8'h20; rq[0] = 1'b1;
    we_v[1] = 1'b0; ad_v[1] = 8'h21; rq[1] = 1'b1;
    ng = 0; both = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (r0_gnt && r1_gnt) both++;
      if (r0_gnt && ng < 4) begin gown[ng] = 1'b0; gcy[ng] = c; ng++; ad_v[0] = 8'($urandom); end
      if (r1_gnt && ng < 4) begin gown[ng] = 1'b1; gcy[ng] = c; ng++; ad_v[1] = 8'($urandom); end
    end
    rq[0] = 1'b0; rq[1] = 1'b0;
    check("cont_grants", 32'(ng), 32'd4);
    check("cont_both_gnt", 32'(both), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("cont_owner", 32'(gown[i]), 32'(i % 2));
      check("cont_gnt_cycle", 32'(gcy[i]), 32'(1 + 4 * i));
    end

    // Reset during ACCESS of an r0 read; r1 starts requesting meanwhile.
    tick();
    we_v[0] = 1'b0; ad_v[0] = 8'h10; rq[0] = 1'b1;
    tick();
    check("rsta_gnt0", 32'(r0_gnt), 32'd1);
    we_v[1] = 1'b0; ad_v[1] = 8'h21; rq[1] = 1'b1;
    tick();
    check("rsta_chip_en_before", 32'(mem_chip_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rsta_chip_en", 32'(mem_chip_en), 32'd0);
    check("rsta_busy", 32'(busy), 32'd0);
    check("rsta_done0", 32'(r0_done), 32'd0);
    check("rsta_gnt0_low", 32'(r0_gnt), 32'd0);
    tick(); tick();
    rst = 1'b0;
    g0 = -1; g1 = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (r0_gnt && g0 < 0) begin g0 = c; rq[0] = 1'b0; end
      if (r1_gnt && g1 < 0) begin g1 = c; rq[1] = 1'b0; end
    end
    check("rsta_gnt0_cycle", 32'(g0), 32'd1);
    check("rsta_gnt1_cycle", 32'(g1), 32'd5);

    // Randomized traffic from both masters.
    for (int n = 0; n < 2; n++) begin
      head[n] = 0;
      gapc[n] = 0;
      for (int i = 0; i < NCMD; i++) begin
        cmd_we[n][i]  = 1'($urandom);
        cmd_ad[n][i]  = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                     : 8'(8'hF0 + $urandom_range(0, 7));
        cmd_wd[n][i]  = 8'($urandom);
        cmd_gap[n][i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
      end
    end
    ngr = 0;
    for (cy = 0; cy < 3000; cy++) begin
      if (head[0] == NCMD && head[1] == NCMD && !busy) break;
      tick();
      ngr += int'(r0_gnt) + int'(r1_gnt);
      drive_step();
    end
    check("rand_completed", 32'(cy < 3000), 32'd1);
    check("rand_grant_count", 32'(ngr), 32'(2 * NCMD));
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
